alu_seq: RTL and testbench

- Parametrised, multi-cycle signed ALU that succeeds the fixed 8-bit combinational ALU. It performs add, sub, mul and div.
- Operands arrive on a valid/ready request channel. The result leaves on a valid/ready response channel.
- ADD/SUB complete in one cycle. MUL and DIV are iterative, one bit per cycle, which saves area over array logic.
- Sits between an operand source (register file or test driver) and a result sink. Supports back-pressure on both sides.

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_seq_divider.sv | 63 ++++++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op encodings and FSM state type for the sequential signed ALU.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done is combinational on the final iteration; quotient/remainder are valid while done is high.
module alu_seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q, r, d;
  logic [WIDTH-1:0] q_next, r_next;
  logic [WIDTH:0]   r_shift, diff;
  logic [CW-1:0]    cnt;
  logic             busy;

  // Partial remainder stays below d, so WIDTH+1 bits hold the shifted value and its sign.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    diff    = r_shift - {1'b0, d};
    if (!diff[WIDTH]) begin
      r_next = diff[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_shift[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

  assign done      = busy && (cnt == CW'(1));
  assign quotient  = q_next;
  assign remainder = r_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      r    <= '0;
      d    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
      cnt  <= CW'(WIDTH);
      busy <= 1'b1;
    end else if (busy) begin
      q   <= q_next;
      r   <= r_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1))
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle signed ALU (add/sub/mul/div) with valid/ready request and response channels.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op=3 returns result 0 with err set.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  input  logic [1:0]                op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] result,
  output logic                      err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t             state, state_next;
  logic [1:0]         op_reg;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, mplier;
  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0] acc, mcand, acc_next, mul_res;
  logic [CW-1:0]      cnt;
  logic               accept, last_iter;

  assign accept    = in_valid && (state == IDLE);
  assign last_iter = (cnt == CW'(1));
  assign a_ext     = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_ext     = {{WIDTH{B[WIDTH-1]}}, B};
  // Magnitude of -2^(W-1) is 2^(W-1), which still fits unsigned in WIDTH bits.
  assign a_mag     = A[WIDTH-1] ? ('0 - A) : A;
  assign b_mag     = B[WIDTH-1] ? ('0 - B) : B;
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;
  assign mul_res   = (a_neg ^ b_neg) ? ('0 - acc_next) : acc_next;

`ifdef ALU_SEQ_DIV_EN
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem, quo_s, rem_s;

  assign div_start = accept && (op == OP_DIV) && (B != '0);
  assign quo_s     = (a_neg ^ b_neg) ? ('0 - div_quo) : div_quo;
  assign rem_s     = a_neg ? ('0 - div_rem) : div_rem;

  alu_seq_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          unique case (op)
            OP_ADD, OP_SUB: state_next = DONE;
            OP_MUL:         state_next = BUSY;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV:         state_next = (B == '0) ? DONE : BUSY;
`else
            OP_DIV:         state_next = DONE;
`endif
          endcase
        end
      end
      BUSY: begin
`ifdef ALU_SEQ_DIV_EN
        if ((op_reg == OP_DIV) ? div_done : last_iter)
          state_next = DONE;
`else
        if (last_iter)
          state_next = DONE;
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg <= OP_ADD;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_reg <= op;
            a_neg  <= A[WIDTH-1];
            b_neg  <= B[WIDTH-1];
            err    <= 1'b0;
            unique case (op)
              OP_ADD: result <= a_ext + b_ext;
              OP_SUB: result <= a_ext - b_ext;
              OP_MUL: begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                cnt    <= CW'(WIDTH);
              end
              OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (B == '0) begin
                  result <= {A, {WIDTH{1'b1}}};
                  err    <= 1'b1;
                end else begin
                  cnt <= CW'(WIDTH);
                end
`else
                result <= '0;
                err    <= 1'b1;
`endif
              end
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (op_reg == OP_MUL) begin
            acc    <= acc_next;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            if (last_iter)
              result <= mul_res;
          end
`ifdef ALU_SEQ_DIV_EN
          if (op_reg == OP_DIV && div_done)
            result <= {rem_s, quo_s};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed, random, back-pressure and mid-op reset.
module tb_alu_seq;

  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] A = '0;
  logic signed [7:0] B = '0;
  logic [1:0]        op = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [15:0] result;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  // Reference: plain integer arithmetic on the signed operands.
  function automatic void model(input logic [1:0] o, input logic signed [7:0] a,
                                input logic signed [7:0] b, output logic [15:0] res,
                                output logic e, output int lat);
    int ai, bi, q, r;
    ai = a;
    bi = b;
    e = 1'b0;
    lat = 1;
    res = '0;
    q = 0;
    r = 0;
    case (o)
      2'd0: res = 16'(ai + bi);
      2'd1: res = 16'(ai - bi);
      2'd2: begin res = 16'(ai * bi); lat = W + 1; end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        if (bi == 0) begin
          res = {a, 8'hFF};
          e = 1'b1;
        end else begin
          q = ai / bi;
          r = ai % bi;
          res = {8'(r), 8'(q)};
          lat = W + 1;
        end
`else
        res = '0;
        e = 1'b1;
`endif
      end
    endcase
  endfunction

  // Drives one request, measures latency, captures the first valid result, then completes the response.
  task automatic run_op(input logic [1:0] o, input logic signed [7:0] a, input logic signed [7:0] b,
                        input int hold, output logic [15:0] res, output logic e, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); op = 2'($urandom);
    lat = 1;
    while (!out_valid && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    e = err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got %h want 0000", result); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]        ops [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    logic signed [7:0] as  [8] = '{8'sd100, -8'sd128, -8'sd128, -8'sd3, -8'sd7, 8'sd5, -8'sd128, -8'sd128};
    logic signed [7:0] bs  [8] = '{8'sd50, 8'sd1, -8'sd128, 8'sd7, 8'sd2, 8'sd0, -8'sd1, -8'sd1};
    logic [15:0] res, exp_res;
    logic e, exp_e;
    int lat, exp_lat;
    for (int i = 0; i < 8; i++) begin
      model(ops[i], as[i], bs[i], exp_res, exp_e, exp_lat);
      run_op(ops[i], as[i], bs[i], 0, res, e, lat);
      n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL dir%0d_result op=%0d got %h want %h", i, ops[i], res, exp_res); end
      n_checks++; if (e !== exp_e) begin n_fail++; $display("FAIL dir%0d_err got %b want %b", i, e, exp_e); end
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic signed [7:0] a, b;
    logic [15:0] res, exp_res;
    logic e, exp_e;
    int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'sd0 : 8'($urandom);
      model(o, a, b, exp_res, exp_e, exp_lat);
      run_op(o, a, b, $urandom_range(0, 2), res, e, lat);
      n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%0d b=%0d got %h want %h", i, o, a, b, res, exp_res); end
      n_checks++; if (e !== exp_e) begin n_fail++; $display("FAIL rnd%0d_err got %b want %b", i, e, exp_e); end
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [15:0] exp_res, res;
    logic exp_e, e;
    int exp_lat, lat;
    model(2'd2, -8'sd3, 8'sd7, exp_res, exp_e, exp_lat);
    op = 2'd2; A = -8'sd3; B = 8'sd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, exp_lat); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (result !== exp_res) begin n_fail++; $display("FAIL bp_hold%0d_result got %h want %h", i, result, exp_res); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d_out_valid got %b want 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d_in_ready got %b want 0", i, in_ready); end
      in_valid = (i % 2 == 0);
      op = 2'd0; A = 8'sd1; B = 8'sd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    model(2'd0, 8'sd2, 8'sd3, exp_res, exp_e, exp_lat);
    run_op(2'd0, 8'sd2, 8'sd3, 0, res, e, lat);
    n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL bp_next_result got %h want %h", res, exp_res); end
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL bp_next_latency got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] res;
    logic e;
    int lat;
    logic seen_valid;
    op = 2'd2; A = 8'sd3; B = 8'sd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result got %h want 0000", result); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result got %b want 0", seen_valid); end
    run_op(2'd0, 8'sd1, 8'sd1, 0, res, e, lat);
    n_checks++; if (res !== 16'h0002) begin n_fail++; $display("FAIL midrst_add_result got %h want 0002", res); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL midrst_add_latency got %0d want 1", lat); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
